// File: rtl/sensor_frame_ctrl.sv
// Sensor frame sequencer: resets the sensor, grants frames continuously or one per
// trigger, and shadows the timing parameters so they only change between frames.
module sensor_frame_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned PARAM_W        = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_stream_en,
  input  logic               i_trigger_mode,
  input  logic               i_trigger,
  input  logic [15:0]        iv_frame_num,
  input  logic [PARAM_W-1:0] iv_width,
  input  logic [PARAM_W-1:0] iv_line_hide,
  input  logic [PARAM_W-1:0] iv_height,
  input  logic [PARAM_W-1:0] iv_frame_hide,
  input  logic [PARAM_W-1:0] iv_front_porch,
  input  logic [PARAM_W-1:0] iv_back_porch,
  input  logic               i_fval,
  output logic               o_sensor_reset,
  output logic               o_pause_en,
  output logic [PARAM_W-1:0] ov_width,
  output logic [PARAM_W-1:0] ov_line_hide,
  output logic [PARAM_W-1:0] ov_height,
  output logic [PARAM_W-1:0] ov_frame_hide,
  output logic [PARAM_W-1:0] ov_front_porch,
  output logic [PARAM_W-1:0] ov_back_porch,
  output logic [15:0]        ov_frame_cnt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_trigger_miss,
  output logic               o_timeout
);

  localparam int unsigned RST_W = 8;
  localparam int unsigned TO_W  = 20;
  localparam int unsigned CNT_W = 16;

  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_WAIT,
    S_RUN,
    S_FRAME
  } state_e;

  state_e             state_q, state_d;
  logic               fval_q;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               sensor_reset_q, sensor_reset_d;
  logic               pause_en_q, pause_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               miss_q, miss_d;
  logic               timeout_q, timeout_d;

  logic [PARAM_W-1:0] width_q, line_hide_q, height_q;
  logic [PARAM_W-1:0] frame_hide_q, front_porch_q, back_porch_q;

  logic               rise, fall, load_shadow;
  logic [TO_W-1:0]    to_cnt_inc;
  logic [CNT_W-1:0]   frame_cnt_inc;

  assign rise          = i_fval & ~fval_q;
  assign fall          = ~i_fval & fval_q;
  assign to_cnt_inc    = to_cnt_q + TO_W'(1);
  assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      fval_q         <= 1'b0;
      rst_cnt_q      <= '0;
      to_cnt_q       <= '0;
      frame_cnt_q    <= '0;
      sensor_reset_q <= 1'b0;
      pause_en_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      miss_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fval_q         <= i_fval;
      rst_cnt_q      <= rst_cnt_d;
      to_cnt_q       <= to_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      sensor_reset_q <= sensor_reset_d;
      pause_en_q     <= pause_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      miss_q         <= miss_d;
      timeout_q      <= timeout_d;
    end
  end

  // Next-state and next-output logic; the timeout counter clears whenever RUN is left
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = '0;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    load_shadow = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        load_shadow = 1'b1;
        if (i_stream_en) begin
          frame_cnt_d = '0;
          rst_cnt_d   = RST_LOAD;
          state_d     = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt_q == '0) begin
          state_d = S_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      S_WAIT: begin
        load_shadow = 1'b1;
        if (!i_stream_en) begin
          state_d = S_IDLE;
        end else if (!i_trigger_mode || i_trigger) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_stream_en) begin
          state_d = S_IDLE;
        end else if (rise) begin
          state_d = S_FRAME;
        end else if (to_cnt_inc == TO_LIMIT) begin
          timeout_d = 1'b1;
          rst_cnt_d = RST_LOAD;
          state_d   = S_RST;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      S_FRAME: begin
        if (fall) begin
          load_shadow = 1'b1;
          frame_cnt_d = frame_cnt_inc;
          if ((iv_frame_num != '0) && (frame_cnt_inc == iv_frame_num)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (!i_stream_en) begin
            state_d = S_IDLE;
          end else if (!i_trigger_mode) begin
            state_d = S_RUN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    sensor_reset_d = (state_d == S_RST);
    busy_d         = (state_d != S_IDLE);
    // Inside a frame the pause request follows the mode, granting a single frame per trigger
    if (state_d == S_RUN) begin
      pause_en_d = 1'b0;
    end else if (state_d == S_FRAME) begin
      pause_en_d = i_trigger_mode;
    end else begin
      pause_en_d = 1'b1;
    end
    miss_d = i_trigger & ~((state_q == S_WAIT) & i_trigger_mode);
  end

  // Shadow timing registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_q       <= '0;
      line_hide_q   <= '0;
      height_q      <= '0;
      frame_hide_q  <= '0;
      front_porch_q <= '0;
      back_porch_q  <= '0;
    end else if (load_shadow) begin
      width_q       <= iv_width;
      line_hide_q   <= iv_line_hide;
      height_q      <= iv_height;
      frame_hide_q  <= iv_frame_hide;
      front_porch_q <= iv_front_porch;
      back_porch_q  <= iv_back_porch;
    end
  end

  assign o_sensor_reset = sensor_reset_q;
  assign o_pause_en     = pause_en_q;
  assign ov_width       = width_q;
  assign ov_line_hide   = line_hide_q;
  assign ov_height      = height_q;
  assign ov_frame_hide  = frame_hide_q;
  assign ov_front_porch = front_porch_q;
  assign ov_back_porch  = back_porch_q;
  assign ov_frame_cnt   = frame_cnt_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_trigger_miss = miss_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Bench for sensor_frame_ctrl: small sensor model, cycle reference model with
// per-cycle comparison, and directed scenarios with hand-computed expectations.
module tb_sensor_frame_ctrl;

  localparam int RSTC = 4;
  localparam int TOC  = 100;
  localparam int FLEN = 8;
  localparam int GAP  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RST   = 1;
  localparam int M_WAIT  = 2;
  localparam int M_RUN   = 3;
  localparam int M_FRAME = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_stream_en, i_trigger_mode, i_trigger, i_fval;
  logic [15:0] iv_frame_num;
  logic [15:0] iv_p [6];
  logic        o_sensor_reset, o_pause_en, o_busy, o_done, o_trigger_miss, o_timeout;
  logic [15:0] ov_width, ov_line_hide, ov_height, ov_frame_hide, ov_front_porch, ov_back_porch;
  logic [15:0] ov_frame_cnt;
  logic [15:0] act_sh [6];
  string       sh_nm [6] = '{"ov_width", "ov_line_hide", "ov_height",
                             "ov_frame_hide", "ov_front_porch", "ov_back_porch"};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit sens_on = 1'b1;

  always #5 clk = ~clk;

  sensor_frame_ctrl #(
    .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOC), .PARAM_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_stream_en(i_stream_en), .i_trigger_mode(i_trigger_mode), .i_trigger(i_trigger),
    .iv_frame_num(iv_frame_num),
    .iv_width(iv_p[0]), .iv_line_hide(iv_p[1]), .iv_height(iv_p[2]),
    .iv_frame_hide(iv_p[3]), .iv_front_porch(iv_p[4]), .iv_back_porch(iv_p[5]),
    .i_fval(i_fval),
    .o_sensor_reset(o_sensor_reset), .o_pause_en(o_pause_en),
    .ov_width(ov_width), .ov_line_hide(ov_line_hide), .ov_height(ov_height),
    .ov_frame_hide(ov_frame_hide), .ov_front_porch(ov_front_porch), .ov_back_porch(ov_back_porch),
    .ov_frame_cnt(ov_frame_cnt), .o_busy(o_busy), .o_done(o_done),
    .o_trigger_miss(o_trigger_miss), .o_timeout(o_timeout)
  );

  assign act_sh[0] = ov_width;
  assign act_sh[1] = ov_line_hide;
  assign act_sh[2] = ov_height;
  assign act_sh[3] = ov_frame_hide;
  assign act_sh[4] = ov_front_porch;
  assign act_sh[5] = ov_back_porch;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Sensor: emits FLEN-cycle fval pulses separated by at least GAP cycles, only when not paused
  initial begin
    int s_left, s_gap;
    i_fval = 1'b0;
    s_left = 0;
    s_gap  = GAP;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || o_sensor_reset || !sens_on) begin
        i_fval = 1'b0;
        s_left = 0;
        s_gap  = GAP;
      end else if (i_fval) begin
        s_left--;
        if (s_left == 0) begin
          i_fval = 1'b0;
          s_gap  = GAP;
        end
      end else if (s_gap > 0) begin
        s_gap--;
      end else if (!o_pause_en) begin
        i_fval = 1'b1;
        s_left = FLEN;
      end
    end
  end

  // Reference model: phase plus elapsed-time counters, expected register contents after each edge
  int          m_ph, m_rst_el, m_run_el, m_cnt;
  bit          m_fprev;
  logic        e_sreset, e_pause, e_busy, e_done, e_miss, e_timeout;
  logic [15:0] e_cnt;
  logic [15:0] e_sh [6];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = M_IDLE; m_fprev = 1'b0; m_rst_el = 0; m_run_el = 0; m_cnt = 0;
      e_sreset = 1'b0; e_pause = 1'b1; e_busy = 1'b0;
      e_done = 1'b0; e_miss = 1'b0; e_timeout = 1'b0; e_cnt = 16'd0;
      for (int k = 0; k < 6; k++) e_sh[k] = 16'd0;
    end else begin
      bit rise, fall;
      int nx;
      rise = i_fval && !m_fprev;
      fall = !i_fval && m_fprev;
      m_fprev = i_fval;
      e_miss = i_trigger && !(m_ph == M_WAIT && i_trigger_mode);
      e_done = 1'b0;
      e_timeout = 1'b0;
      nx = m_ph;
      if (m_ph == M_IDLE || m_ph == M_WAIT || (m_ph == M_FRAME && fall)) e_sh = iv_p;
      if (m_ph != M_RUN) m_run_el = 0;
      case (m_ph)
        M_IDLE: if (i_stream_en) begin m_cnt = 0; m_rst_el = 0; nx = M_RST; end
        M_RST: begin
          m_rst_el++;
          if (m_rst_el == RSTC) nx = M_WAIT;
        end
        M_WAIT: begin
          if (!i_stream_en) nx = M_IDLE;
          else if (!i_trigger_mode || i_trigger) nx = M_RUN;
        end
        M_RUN: begin
          m_run_el++;
          if (!i_stream_en) nx = M_IDLE;
          else if (rise) nx = M_FRAME;
          else if (m_run_el == TOC) begin e_timeout = 1'b1; m_rst_el = 0; nx = M_RST; end
        end
        default: begin
          if (fall) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (iv_frame_num != 0 && m_cnt == int'(iv_frame_num)) begin e_done = 1'b1; nx = M_IDLE; end
            else if (!i_stream_en) nx = M_IDLE;
            else if (!i_trigger_mode) nx = M_RUN;
            else nx = M_WAIT;
          end
        end
      endcase
      m_ph = nx;
      e_sreset = (m_ph == M_RST);
      e_busy = (m_ph != M_IDLE);
      e_pause = (m_ph == M_RUN) ? 1'b0 : (m_ph == M_FRAME) ? i_trigger_mode : 1'b1;
      e_cnt = 16'(m_cnt);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check1("o_sensor_reset", o_sensor_reset, e_sreset);
      check1("o_pause_en", o_pause_en, e_pause);
      check1("o_busy", o_busy, e_busy);
      check1("o_done", o_done, e_done);
      check1("o_trigger_miss", o_trigger_miss, e_miss);
      check1("o_timeout", o_timeout, e_timeout);
      check16("ov_frame_cnt", ov_frame_cnt, e_cnt);
      for (int k = 0; k < 6; k++) check16(sh_nm[k], act_sh[k], e_sh[k]);
    end
  end

  // Event monitor: cumulative counts, scenarios use differences
  int sr_run = 0, last_sr_len = 0, n_done = 0, n_miss = 0, n_rise = 0;
  bit pf = 1'b0;
  always @(negedge clk) begin
    if (o_sensor_reset === 1'b1) sr_run++;
    else begin
      if (sr_run != 0) last_sr_len = sr_run;
      sr_run = 0;
    end
    if (o_done === 1'b1) n_done++;
    if (o_trigger_miss === 1'b1) n_miss++;
    if (i_fval && !pf) n_rise++;
    pf = i_fval;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, b_done, b_miss, b_rise;
    i_stream_en = 1'b0; i_trigger_mode = 1'b0; i_trigger = 1'b0; iv_frame_num = 16'd0;
    iv_p = '{16'd640, 16'd16, 16'd480, 16'd20, 16'd4, 16'd6};
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    check1("rst_pause", o_pause_en, 1'b1);
    check1("rst_busy", o_busy, 1'b0);
    check1("rst_sreset", o_sensor_reset, 1'b0);
    check16("rst_cnt", ov_frame_cnt, 16'd0);
    check16("rst_width", ov_width, 16'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    check16("idle_width_load", ov_width, 16'd640);

    // Continuous run of three frames
    b_done = n_done; b_rise = n_rise;
    iv_frame_num = 16'd3; i_trigger_mode = 1'b0; i_stream_en = 1'b1;
    n = 0;
    while (!o_done && n < 1000) begin tick(); n++; end
    check1("cont_wait_done", o_done, 1'b1);
    i_stream_en = 1'b0;
    repeat (3) tick();
    check16("cont_cnt", ov_frame_cnt, 16'd3);
    checki("cont_done_pulses", n_done - b_done, 1);
    checki("cont_frames", n_rise - b_rise, 3);
    checki("cont_sreset_len", last_sr_len, 4);
    check1("cont_pause_after", o_pause_en, 1'b1);
    check1("cont_busy_after", o_busy, 1'b0);

    // Trigger mode: two triggers 1000 cycles apart plus one inside a frame
    b_done = n_done; b_rise = n_rise; b_miss = n_miss;
    iv_frame_num = 16'd0; i_trigger_mode = 1'b1; i_stream_en = 1'b1;
    n = 0;
    while (!o_sensor_reset && n < 20) begin tick(); n++; end
    n = 0;
    while (o_sensor_reset && n < 20) begin tick(); n++; end
    check1("trig_in_wait", o_busy && !o_sensor_reset, 1'b1);
    i_trigger = 1'b1; tick(); i_trigger = 1'b0; t = 1;
    n = 0;
    while (!i_fval && n < 50) begin tick(); n++; t++; end
    check1("trig_frame1_start", i_fval, 1'b1);
    repeat (2) begin tick(); t++; end
    i_trigger = 1'b1; tick(); t++; i_trigger = 1'b0;
    while (t < 1000) begin tick(); t++; end
    i_trigger = 1'b1; tick(); i_trigger = 1'b0;
    n = 0;
    while (ov_frame_cnt != 16'd2 && n < 200) begin tick(); n++; end
    check16("trig_cnt", ov_frame_cnt, 16'd2);
    repeat (5) tick();
    check1("trig_pause_hold", o_pause_en, 1'b1);
    i_stream_en = 1'b0;
    repeat (3) tick();
    checki("trig_frames", n_rise - b_rise, 2);
    checki("trig_miss_pulses", n_miss - b_miss, 1);
    checki("trig_done_pulses", n_done - b_done, 0);
    check1("trig_busy_after", o_busy, 1'b0);

    // Shadow update mid-frame
    iv_frame_num = 16'd2; i_trigger_mode = 1'b0; i_stream_en = 1'b1;
    n = 0;
    while (!i_fval && n < 50) begin tick(); n++; end
    repeat (2) tick();
    iv_p[0] = 16'd320;
    repeat (2) tick();
    check16("shadow_hold", ov_width, 16'd640);
    n = 0;
    while (ov_frame_cnt != 16'd1 && n < 50) begin tick(); n++; end
    check16("shadow_fall_cnt", ov_frame_cnt, 16'd1);
    check16("shadow_new", ov_width, 16'd320);
    n = 0;
    while (!o_done && n < 100) begin tick(); n++; end
    check1("shadow_wait_done", o_done, 1'b1);
    i_stream_en = 1'b0;
    repeat (3) tick();
    check16("shadow_cnt", ov_frame_cnt, 16'd2);

    // Timeout after one frame, then a fresh sensor reset pulse
    iv_frame_num = 16'd0; i_stream_en = 1'b1;
    n = 0;
    while (ov_frame_cnt != 16'd1 && n < 100) begin tick(); n++; end
    sens_on = 1'b0;
    n = 0;
    while (!o_timeout && n < 300) begin n++; tick(); end
    checki("timeout_run_cycles", n, 100);
    check1("timeout_pulse", o_timeout, 1'b1);
    check1("timeout_new_rst", o_sensor_reset, 1'b1);
    check16("timeout_cnt_kept", ov_frame_cnt, 16'd1);
    i_stream_en = 1'b0; sens_on = 1'b1;
    n = 0;
    while (o_busy && n < 30) begin tick(); n++; end
    check1("timeout_idle", o_busy, 1'b0);
    checki("timeout_sreset_len", last_sr_len, 4);

    // Stream disable inside a frame completes that frame
    b_done = n_done;
    i_stream_en = 1'b1;
    n = 0;
    while (!i_fval && n < 50) begin tick(); n++; end
    tick();
    i_stream_en = 1'b0;
    n = 0;
    while (o_busy && n < 50) begin tick(); n++; end
    check1("stop_idle", o_busy, 1'b0);
    check16("stop_cnt", ov_frame_cnt, 16'd1);
    checki("stop_no_done", n_done - b_done, 0);
    check1("stop_pause", o_pause_en, 1'b1);

    // Reset asserted inside the second frame
    b_done = n_done;
    iv_frame_num = 16'd5; i_stream_en = 1'b1;
    n = 0;
    while (!(ov_frame_cnt == 16'd1 && i_fval) && n < 200) begin tick(); n++; end
    check1("rstmid_in_frame", i_fval, 1'b1);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check1("rstmid_busy", o_busy, 1'b0);
    check1("rstmid_pause", o_pause_en, 1'b1);
    check1("rstmid_sreset", o_sensor_reset, 1'b0);
    check16("rstmid_cnt", ov_frame_cnt, 16'd0);
    check16("rstmid_width", ov_width, 16'd0);
    i_stream_en = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    checki("rstmid_no_done", n_done - b_done, 0);
    check1("rstmid_idle", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
